qsys_system_nios2_qsys_0_mul_seq: RTL and testbench

//  Multiply sequencer directly upstream of the Nios II multiplier cell. Accepts mul requests on a

---
 rtl/qsys_system_nios2_qsys_0_mul_seq.sv | 173 +++++++++++++++++
 tb/tb_qsys_system_nios2_qsys_0_mul_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/qsys_system_nios2_qsys_0_mul_seq.sv
// Multiply sequencer feeding the Nios II multiplier cell: MUL low word, MULX* high word via four 16x16 passes.
// Define QSYS_NIOS2_MUL_SIGNED_EN to add the FIX state that corrects MULXSS/MULXSU to signed results.
module qsys_system_nios2_qsys_0_mul_seq #(
   parameter int unsigned CELL_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_src1,
   input  logic [31:0] in_src2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [31:0] A_mul_src1,
   output logic [31:0] A_mul_src2,
   input  logic [31:0] A_mul_cell_result
);

   localparam int unsigned CNT_W = $clog2(CELL_LATENCY + 5);
   localparam logic [CNT_W-1:0] CAP_FIRST   = CNT_W'(CELL_LATENCY);
   localparam logic [CNT_W-1:0] CAP_LAST_HI = CNT_W'(CELL_LATENCY + 3);
   localparam logic [CNT_W-1:0] LAST_ISSUE  = CNT_W'(3);
   localparam logic [1:0]       OP_MUL      = 2'b00;

`ifdef QSYS_NIOS2_MUL_SIGNED_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

   state_t            r_state;
   state_t            w_state_next;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [31:0]       r_out_result;
   logic [31:0]       r_src1;
   logic [31:0]       r_src2;
   logic [1:0]        r_op;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [63:0]       r_acc;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_is_mul;
   logic              w_need_fix;
   logic              w_cap;
   logic              w_last;
   logic              w_issue;
   logic [1:0]        w_cap_idx;
   logic [1:0]        w_issue_idx;
   logic [63:0]       w_partial;
   logic [63:0]       w_acc_sum;

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign A_mul_src1 = r_src1;
   assign A_mul_src2 = r_src2;

   // Zero-extended 16-bit halves for pass k, packed {src1, src2}; order ll, lh, hl, hh.
   function automatic logic [63:0] f_pass(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b);
      case (k)
         2'd0:    f_pass = {16'h0, a[15:0],  16'h0, b[15:0]};
         2'd1:    f_pass = {16'h0, a[15:0],  16'h0, b[31:16]};
         2'd2:    f_pass = {16'h0, a[31:16], 16'h0, b[15:0]};
         default: f_pass = {16'h0, a[31:16], 16'h0, b[31:16]};
      endcase
   endfunction

   assign w_is_mul    = (r_op == OP_MUL);
   assign w_cap       = (r_state == S_RUN) && (r_cnt >= CAP_FIRST);
   assign w_cap_idx   = 2'(r_cnt - CAP_FIRST);
   assign w_last      = w_cap && (r_cnt == (w_is_mul ? CAP_FIRST : CAP_LAST_HI));
   assign w_issue     = !w_is_mul && (r_cnt < LAST_ISSUE);
   assign w_issue_idx = 2'(r_cnt + CNT_W'(1));
   assign w_acc_sum   = r_acc + w_partial;

`ifdef QSYS_NIOS2_MUL_SIGNED_EN
   logic [31:0] w_corr;
   assign w_need_fix = r_op[1];
   // Two's-complement fix-up of the unsigned high word; b is only signed for MULXSS.
   assign w_corr = (r_a[31] ? r_b : 32'h0) + ((r_op == 2'b10 && r_b[31]) ? r_a : 32'h0);
`else
   assign w_need_fix = 1'b0;
`endif

   always_comb begin
      w_partial = 64'h0;
      case (w_cap_idx)
         2'd0:    w_partial = {32'h0, A_mul_cell_result};
         2'd1,
         2'd2:    w_partial = {16'h0, A_mul_cell_result, 16'h0};
         default: w_partial = {A_mul_cell_result, 32'h0};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_state_next = S_RUN;
`ifdef QSYS_NIOS2_MUL_SIGNED_EN
         S_RUN:  if (w_last) w_state_next = (!w_is_mul && w_need_fix) ? S_FIX : S_DONE;
         S_FIX:  w_state_next = S_DONE;
`else
         S_RUN:  if (w_last) w_state_next = S_DONE;
`endif
         S_DONE: if (out_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_result <= 32'h0;
         r_src1       <= 32'h0;
         r_src2       <= 32'h0;
         r_op         <= 2'b00;
         r_a          <= 32'h0;
         r_b          <= 32'h0;
         r_acc        <= 64'h0;
         r_cnt        <= '0;
      end else begin
         r_in_ready <= (w_state_next == S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op  <= in_op;
                  r_a   <= in_src1;
                  r_b   <= in_src2;
                  r_acc <= 64'h0;
                  r_cnt <= '0;
                  // First pass is issued straight from the request operands.
                  if (in_op == OP_MUL) {r_src1, r_src2} <= {in_src1, in_src2};
                  else                 {r_src1, r_src2} <= f_pass(2'd0, in_src1, in_src2);
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_issue) {r_src1, r_src2} <= f_pass(w_issue_idx, r_a, r_b);
               else         {r_src1, r_src2} <= 64'h0;
               if (w_cap) begin
                  if (w_is_mul) r_out_result <= A_mul_cell_result;
                  else          r_acc        <= w_acc_sum;
               end
               if (w_last && !(w_need_fix && !w_is_mul)) begin
                  r_out_valid <= 1'b1;
                  if (!w_is_mul) r_out_result <= w_acc_sum[63:32];
               end
            end
`ifdef QSYS_NIOS2_MUL_SIGNED_EN
            S_FIX: begin
               r_out_result <= r_acc[63:32] - w_corr;
               r_out_valid  <= 1'b1;
            end
`endif
            S_DONE: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_qsys_system_nios2_qsys_0_mul_seq.sv
// Bench for the multiply sequencer: behavioural cell + product model, per-cycle compare, directed literal vectors.
module tb_qsys_system_nios2_qsys_0_mul_seq;

   localparam int unsigned CL = 1;
`ifdef QSYS_NIOS2_MUL_SIGNED_EN
   localparam bit SEN = 1'b1;
`else
   localparam bit SEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_src1;
   logic [31:0] in_src2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [31:0] A_mul_src1;
   logic [31:0] A_mul_src2;
   logic [31:0] A_mul_cell_result;

   int n_vec = 0;
   int n_err = 0;

   qsys_system_nios2_qsys_0_mul_seq #(.CELL_LATENCY(CL)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .A_mul_src1(A_mul_src1), .A_mul_src2(A_mul_src2),
      .A_mul_cell_result(A_mul_cell_result)
   );

   always #5 clk = ~clk;

   // Single-register multiplier cell
   always @(posedge clk) A_mul_cell_result <= A_mul_src1 * A_mul_src2;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Architectural result: 64-bit product of the operands as the op interprets them.
   function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ax, bx, p;
      ax = {32'h0, a};
      bx = {32'h0, b};
      if (SEN && op[1]) ax = {{32{a[31]}}, a};
      if (SEN && op == 2'b10) bx = {{32{b[31]}}, b};
      p = ax * bx;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic int model_lat(input logic [1:0] op);
      if (op == 2'b00) return CL + 1;
      if (SEN && op[1]) return CL + 5;
      return CL + 4;
   endfunction

   // Per-cycle compare against the transaction-level model
   bit          m_busy = 1'b0;
   int          m_age;
   int          m_lat;
   int          m_np;
   logic [31:0] m_exp;
   initial forever begin
      @(posedge clk);
      if (reset) m_busy = 1'b0;
      else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_lat  = model_lat(in_op);
            m_np   = (in_op == 2'b00) ? 1 : 4;
            m_exp  = model_res(in_op, in_src1, in_src2);
         end
      end else if (m_age >= m_lat && out_ready) m_busy = 1'b0;
      else if (m_age < 1000) m_age++;
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_busy && m_age >= m_lat));
      if (m_busy && m_age >= m_lat) chk("out_result", out_result, m_exp);
      if (!m_busy || m_age >= m_np) begin
         chk("src1_idle", A_mul_src1, 32'h0);
         chk("src2_idle", A_mul_src2, 32'h0);
      end
   end

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] lit, input int lit_lat, input int stall, input bit junk);
      int t;
      out_ready = (stall == 0);
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      chk("ready_wait", 32'(in_ready), 32'h1);
      in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
      @(negedge clk);
      in_valid = junk; in_op = 2'($urandom); in_src1 = $urandom; in_src2 = $urandom;
      t = 0;
      while (!out_valid && t < 30) begin
         @(negedge clk);
         t++;
         in_valid = 1'b0;
      end
      in_valid = 1'b0;
      chk("latency", 32'(t), 32'(lit_lat));
      chk("lit_result", out_result, lit);
      if (stall > 0) begin
         repeat (stall) @(negedge clk);
         chk("held_valid", 32'(out_valid), 32'h1);
         chk("held_result", out_result, lit);
         chk("held_ready", 32'(in_ready), 32'h0);
         out_ready = 1'b1;
      end
      @(negedge clk);
      chk("post_valid", 32'(out_valid), 32'h0);
      chk("post_ready", 32'(in_ready), 32'h1);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_src1 = 32'h0; in_src2 = 32'h0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'h1);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_result", out_result, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, CL + 1, 0, 1'b0);
      run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, CL + 4, 0, 1'b1);
      run(2'b01, 32'h00010000, 32'h00010000, 32'h00000001, CL + 4, 0, 1'b0);
      run(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, SEN ? 32'h00000000 : 32'hFFFFFFFE, SEN ? CL + 5 : CL + 4, 0, 1'b0);
      run(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, SEN ? 32'hFFFFFFFF : 32'hFFFFFFFE, SEN ? CL + 5 : CL + 4, 0, 1'b1);
      run(2'b10, 32'h80000000, 32'h80000000, 32'h40000000, SEN ? CL + 5 : CL + 4, 0, 1'b0);
      run(2'b11, 32'h80000000, 32'h00000002, SEN ? 32'hFFFFFFFF : 32'h00000001, SEN ? CL + 5 : CL + 4, 0, 1'b0);
      run(2'b10, 32'hFFFFFFFE, 32'h00000003, SEN ? 32'hFFFFFFFF : 32'h00000002, SEN ? CL + 5 : CL + 4, 0, 1'b0);
      run(2'b00, 32'hDEADBEEF, 32'h00000002, 32'hBD5B7DDE, CL + 1, 0, 1'b0);
      run(2'b01, 32'hDEADBEEF, 32'h00000002, 32'h00000001, CL + 4, 0, 1'b0);
      run(2'b00, 32'h12345678, 32'h00000010, 32'h23456780, CL + 1, 10, 1'b0);
      run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, CL + 4, 10, 1'b0);

      // Abort a MULXUU mid-run with a one-cycle reset
      in_valid = 1'b1; in_op = 2'b01; in_src1 = 32'hFFFFFFFF; in_src2 = 32'hFFFFFFFF;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_valid", 32'(out_valid), 32'h0);
      chk("abort_ready", 32'(in_ready), 32'h1);
      chk("abort_result", out_result, 32'h0);
      chk("abort_src1", A_mul_src1, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_quiet", 32'(out_valid), 32'h0);
      end
      run(2'b00, 32'h00000003, 32'h00000005, 32'h0000000F, CL + 1, 0, 1'b0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
